// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART with AXI-Stream byte interfaces and a run-time prescale.
// Define UART_CORE_LOOPBACK_EN to add a loopback input that feeds txd into the receiver.
module uart_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  rx_busy,
  input  logic [15:0]           prescale,
  output logic                  rx_overrun_error,
  output logic                  rx_frame_error
`ifdef UART_CORE_LOOPBACK_EN
  ,
  input  logic                  loopback
`endif
);
  localparam int CW = 19;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  // Reload values are "period minus one" so a counter reaching zero marks the last clock.
  function automatic logic [CW-1:0] bit_m1(input logic [15:0] p);
    return {(p == 16'd0 ? 16'd1 : p), 3'b000} - CW'(1);
  endfunction
  function automatic logic [CW-1:0] half_m1(input logic [15:0] p);
    return {1'b0, (p == 16'd0 ? 16'd1 : p), 2'b00} - CW'(1);
  endfunction
  state_t                tx_state, tx_next;
  logic                  tx_armed;
  logic [CW-1:0]         tx_cnt;
  logic [15:0]           tx_p;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [4:0]            tx_idx;
  logic                  tx_tick, tx_last, tx_go;
  assign tx_tick = tx_cnt == '0;
  assign tx_last = tx_idx == 5'(DATA_WIDTH - 1);
  assign tx_go   = s_axis_tvalid && s_axis_tready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) tx_state <= IDLE;
    else      tx_state <= tx_next;
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:    tx_next = tx_go ? START : IDLE;
      START:   tx_next = tx_tick ? DATA : START;
      DATA:    tx_next = tx_tick && tx_last ? STOP : DATA;
      STOP:    tx_next = tx_tick ? IDLE : STOP;
      default: tx_next = IDLE;
    endcase
  end
  always_comb begin
    s_axis_tready = tx_armed && tx_state == IDLE;
    tx_busy       = tx_state != IDLE;
    txd           = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_armed <= 1'b0;
      tx_cnt   <= '0;
      tx_p     <= '0;
      tx_sh    <= '0;
      tx_idx   <= '0;
    end else begin
      tx_armed <= 1'b1;
      if (tx_go) begin
        tx_sh  <= s_axis_tdata;
        tx_p   <= prescale;
        tx_cnt <= bit_m1(prescale);
        tx_idx <= '0;
      end else if (tx_state != IDLE) begin
        tx_cnt <= tx_tick ? bit_m1(tx_p) : tx_cnt - CW'(1);
        if (tx_tick && tx_state == DATA) begin
          tx_sh  <= tx_sh >> 1;
          tx_idx <= tx_idx + 5'd1;
        end
      end
    end
  logic                  rx_in, rx_s1, rx_s;
  state_t                rx_state, rx_next;
  logic [CW-1:0]         rx_cnt;
  logic [15:0]           rx_p;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [DATA_WIDTH:0]   rx_cat;
  logic [4:0]            rx_idx;
  logic                  rx_wait, rx_tick, rx_last, rx_stop;
`ifdef UART_CORE_LOOPBACK_EN
  assign rx_in = loopback ? txd : rxd;
`else
  assign rx_in = rxd;
`endif
  assign rx_tick = rx_cnt == '0;
  assign rx_last = rx_idx == 5'(DATA_WIDTH - 1);
  assign rx_cat  = {rx_s, rx_sh};
  assign rx_stop = rx_state == STOP && rx_tick;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rx_state <= IDLE;
    else      rx_state <= rx_next;
  // rx_wait holds off re-arming after a frame until the line has gone idle again.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    rx_next = !rx_s && !rx_wait ? START : IDLE;
      START:   rx_next = rx_tick ? (rx_s ? IDLE : DATA) : START;
      DATA:    rx_next = rx_tick && rx_last ? STOP : DATA;
      STOP:    rx_next = rx_tick ? IDLE : STOP;
      default: rx_next = IDLE;
    endcase
  end
  always_comb rx_busy = rx_state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_s1            <= 1'b1;
      rx_s             <= 1'b1;
      rx_cnt           <= '0;
      rx_p             <= '0;
      rx_sh            <= '0;
      rx_idx           <= '0;
      rx_wait          <= 1'b0;
      m_axis_tdata     <= '0;
      m_axis_tvalid    <= 1'b0;
      rx_overrun_error <= 1'b0;
      rx_frame_error   <= 1'b0;
    end else begin
      rx_s1 <= rx_in;
      rx_s  <= rx_s1;
      if (rx_state == IDLE && rx_next == START) begin
        rx_p   <= prescale;
        rx_cnt <= half_m1(prescale);
        rx_idx <= '0;
      end else if (rx_state != IDLE) begin
        rx_cnt <= rx_tick ? bit_m1(rx_p) : rx_cnt - CW'(1);
        if (rx_tick && rx_state == DATA) begin
          rx_sh  <= rx_cat[DATA_WIDTH:1];
          rx_idx <= rx_idx + 5'd1;
        end
      end
      rx_wait          <= rx_stop ? 1'b1 : rx_s ? 1'b0 : rx_wait;
      m_axis_tdata     <= rx_stop && rx_s ? rx_sh : m_axis_tdata;
      m_axis_tvalid    <= rx_stop && rx_s ? 1'b1 : m_axis_tready ? 1'b0 : m_axis_tvalid;
      rx_overrun_error <= rx_stop && rx_s && m_axis_tvalid && !m_axis_tready;
      rx_frame_error   <= rx_stop && !rx_s;
    end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks of uart_core TX timing, RX framing, errors and loopback.
module tb_uart_core;
  logic       clk = 0;
  logic       rst;
  logic [7:0] s_tdata, m_tdata;
  logic       s_tvalid, s_tready, m_tvalid, m_tready;
  logic       rxd, rxd_drv, lb, txd, tx_busy, rx_busy, ovr, fe;
  logic [15:0] prescale;
  int n_tests = 0, n_fail = 0, n_ovr = 0, n_fe = 0, o0, f0;
  always #5 clk = ~clk;
  uart_core dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .rxd(rxd), .txd(txd), .tx_busy(tx_busy), .rx_busy(rx_busy),
    .prescale(prescale), .rx_overrun_error(ovr), .rx_frame_error(fe)
`ifdef UART_CORE_LOOPBACK_EN
    , .loopback(lb)
`endif
  );
`ifdef UART_CORE_LOOPBACK_EN
  assign rxd = rxd_drv;
`else
  assign rxd = lb ? txd : rxd_drv;
`endif
  always @(negedge clk) begin
    if (ovr) n_ovr++;
    if (fe) n_fe++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // pat holds the ten line levels in time order (bit 0 = start bit).
  task automatic tx_frame(input logic [7:0] d, input logic [9:0] pat, input int t);
    int busy = 0, bad = 0;
    @(negedge clk);
    s_tdata = d;
    s_tvalid = 1;
    @(negedge clk);
    s_tvalid = 0;
    for (int k = 0; k < 10 * t; k++) begin
      if (txd !== pat[k / t]) bad++;
      if (k % t == t / 2) check("tx_bit", txd, pat[k / t]);
      if (tx_busy) busy++;
      @(negedge clk);
    end
    check("tx_hold", bad, 0);
    check("tx_busy_len", busy, 10 * t);
    check("tx_idle_ready", {tx_busy, s_tready}, 2'b01);
  endtask
  task automatic rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (8) @(negedge clk);
    end
    rxd_drv = 1;
  endtask
  task automatic consume;
    m_tready = 1;
    @(negedge clk);
    m_tready = 0;
    check("tvalid_cleared", m_tvalid, 0);
  endtask
  initial begin
    rst = 0; prescale = 1; s_tvalid = 0; s_tdata = 0; m_tready = 0; rxd_drv = 1; lb = 0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_tready", s_tready, 0);
    check("rst_busy", {tx_busy, rx_busy}, 0);
    check("rst_m", {m_tvalid, m_tdata}, 0);
    check("rst_err", {ovr, fe}, 0);
    rst = 1;
    @(negedge clk);
    check("ready_after_rst", s_tready, 1);
    tx_frame(8'hA5, 10'b1101001010, 8);
    o0 = n_ovr; f0 = n_fe;
    rx_frame(8'h3C, 1);
    repeat (2) @(negedge clk);
    check("rx_valid", m_tvalid, 1);
    check("rx_data", m_tdata, 8'h3C);
    check("rx_no_err", {n_ovr - o0, n_fe - f0}, 0);
    check("rx_busy_done", rx_busy, 0);
    consume();
    o0 = n_ovr;
    rx_frame(8'h11, 1);
    rx_frame(8'h22, 1);
    repeat (2) @(negedge clk);
    check("ovr_count", n_ovr - o0, 1);
    check("ovr_data", m_tdata, 8'h22);
    check("ovr_valid", m_tvalid, 1);
    consume();
    f0 = n_fe;
    rx_frame(8'h55, 0);
    repeat (4) @(negedge clk);
    check("fe_count", n_fe - f0, 1);
    check("fe_valid", m_tvalid, 0);
    f0 = n_fe; o0 = n_ovr;
    rxd_drv = 0;
    repeat (3) @(negedge clk);
    check("glitch_busy", rx_busy, 1);
    rxd_drv = 1;
    repeat (20) @(negedge clk);
    check("glitch_idle", rx_busy, 0);
    check("glitch_valid", m_tvalid, 0);
    check("glitch_err", {n_ovr - o0, n_fe - f0}, 0);
    prescale = 0;
    tx_frame(8'h81, 10'b1100000010, 8);
    rx_frame(8'hC3, 1);
    repeat (2) @(negedge clk);
    check("p0_rx_data", {m_tvalid, m_tdata}, 9'h1C3);
    consume();
    prescale = 4; lb = 1; f0 = n_fe;
    tx_frame(8'hFF, 10'b1111111110, 32);
    repeat (4) @(negedge clk);
    check("lb_data", {m_tvalid, m_tdata}, 9'h1FF);
    check("lb_no_fe", n_fe - f0, 0);
    lb = 0;
    consume();
    prescale = 1;
    @(negedge clk);
    s_tdata = 8'h00;
    s_tvalid = 1;
    @(negedge clk);
    s_tvalid = 0;
    repeat (20) @(negedge clk);
    check("mid_busy", tx_busy, 1);
    #2 rst = 0;
    #1;
    check("abort_txd", txd, 1);
    check("abort_state", {tx_busy, s_tready}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex 8N1 UART transceiver for the iCE40 UART-ALU design.
- It sits between the board serial pins and the ALU datapath.
- It converts AXI-Stream bytes to and from serial frames.
- Baud rate is set at run time by a prescale input: bit time = prescale*8 clk cycles.

Parameters:
- DATA_WIDTH, 8, data bits per frame (1..16); sent and received LSB first.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- s_axis_tdata  in  DATA_WIDTH  byte to transmit.
- s_axis_tvalid  in  1  transmit data valid.
- s_axis_tready  out  1  transmitter can accept a byte.
- m_axis_tdata  out  DATA_WIDTH  received byte.
- m_axis_tvalid  out  1  received byte valid.
- m_axis_tready  in  1  consumer accepts received byte.
- rxd  in  1  serial input, idle high.
- txd  out  1  serial output, idle high.
- tx_busy  out  1  transmit frame in progress.
- rx_busy  out  1  receive frame in progress.
- rx_overrun_error  out  1  one-cycle pulse: new byte arrived while previous byte still unread.
- rx_frame_error  out  1  one-cycle pulse: stop bit sampled low.
- prescale  in  16  clocks per 1/8 bit; 0 treated as 1.

Behaviour:
- Reset values (rst=0, asynchronous): txd=1, s_axis_tready=0, tx_busy=0, m_axis_tdata=0, m_axis_tvalid=0, rx_busy=0, both error outputs 0, all counters 0.
- s_axis_tready rises one cycle after reset release when TX is idle.
- Bit period T = max(prescale,1)*8 clocks. prescale is latched at frame start; changes mid-frame are ignored.
- TX states: IDLE, START, DATA, STOP.
  - IDLE: s_axis_tready=1. On s_axis_tvalid&s_axis_tready, latch data; next cycle s_axis_tready=0, tx_busy=1, txd=0 (start bit).
  - START, DATA and STOP each hold txd for exactly T clocks.
  - DATA sends DATA_WIDTH bits LSB first; STOP drives txd=1.
  - After STOP: tx_busy=0 and s_axis_tready=1 in the same cycle. Total frame = (DATA_WIDTH+2)*T clocks.
  - No gap is inserted between back-to-back frames.
  - s_axis_tvalid is ignored while s_axis_tready=0.
- RX input: rxd passes through a 2-flop synchronizer before any use (adds 2 cycles latency).
- RX states: IDLE, START, DATA, STOP.
  - IDLE: a low on the synchronized rxd enters START and sets rx_busy=1.
  - START: wait T/2 clocks, resample. If high, treat as a glitch and return to IDLE (rx_busy=0, no output). If low, go to DATA.
  - DATA: sample at each bit centre (every T clocks) into a shift register, LSB first.
  - STOP: sample after a further T clocks.
    - Stop=1: load m_axis_tdata and set m_axis_tvalid=1. If m_axis_tvalid was already 1 that cycle, also pulse rx_overrun_error for 1 cycle; new data overwrites old.
    - Stop=0: pulse rx_frame_error for 1 cycle, discard the byte, leave m_axis_tvalid unchanged.
  - rx_busy clears in the stop-sample cycle.
  - After STOP, wait for rxd high before re-arming (a break does not restart).
- m_axis_tvalid clears on the cycle after m_axis_tvalid&m_axis_tready.
- Simultaneous new byte and tready: the new byte wins (tvalid stays 1, no overrun).
- Reset mid-frame aborts immediately to reset values; txd returns high.
- TX and RX are fully independent.

Optional Feature:
- Macro UART_CORE_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the RX synchronizer input is txd instead of rxd, and txd is still driven to the pin.
- Undefined: no loopback port; RX always uses rxd.
- Both variants are otherwise identical.

Test Plan:
- Reset, prescale=1 -> txd=1, s_axis_tready=1 after release, m_axis_tvalid=0, all busy/error signals 0.
- Send 0xA5, prescale=1 -> txd pattern 0,1,0,1,0,0,1,0,1,1, each held 8 clocks. tx_busy high 80 clocks, then s_axis_tready=1.
- Drive rxd with frame 0x3C at T=8, m_axis_tready=0 -> m_axis_tvalid=1, m_axis_tdata=0x3C, no error pulses. Then tready=1 for one cycle -> tvalid=0.
- Two frames 0x11 then 0x22, tready held 0 -> rx_overrun_error pulses once, m_axis_tdata=0x22.
- Frame 0x55 with stop bit forced 0 -> rx_frame_error pulses once, m_axis_tvalid stays 0. A 3-clock low glitch on idle rxd -> no output, rx_busy returns to 0.
- prescale=0 behaves as 1. prescale=4 -> bit time 32 clocks, round-trip 0xFF via loopback (UART_CORE_LOOPBACK_EN) received intact.
